// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, status codes, condition and ALU
// function codes, plus the E->M pipeline register layout and its bubble value.
package y86_pkg;

  localparam int unsigned W = 64;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_CMOVXX = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [1:0] STAT_INS = 2'd0;
  localparam logic [1:0] STAT_AOK = 2'd1;
  localparam logic [1:0] STAT_HLT = 2'd2;
  localparam logic [1:0] STAT_ADR = 2'd3;

  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  localparam logic [3:0] A_ADD = 4'h0;
  localparam logic [3:0] A_SUB = 4'h1;
  localparam logic [3:0] A_AND = 4'h2;
  localparam logic [3:0] A_XOR = 4'h3;

  localparam logic [3:0] RNONE = 4'hF;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

  typedef struct packed {
    logic [1:0]   stat;
    logic [3:0]   icode;
    logic         cnd;
    logic [W-1:0] val_e;
    logic [W-1:0] val_a;
    logic [3:0]   dst_e;
    logic [3:0]   dst_m;
  } m_reg_t;

  function automatic m_reg_t m_bubble_value();
    m_reg_t b;
    b.stat  = STAT_AOK;
    b.icode = I_NOP;
    b.cnd   = 1'b0;
    b.val_e = '0;
    b.val_a = '0;
    b.dst_e = RNONE;
    b.dst_m = RNONE;
    return b;
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Branch/cmov condition evaluator: maps a condition function code and the
// current ZF/SF/OF to a single taken/move bit. Shared with fetch-side logic.
module cond_eval
  import y86_pkg::*;
(
  input  logic [3:0] ifun,
  input  logic       zf,
  input  logic       sf,
  input  logic       of,
  output logic       cnd
);

  logic lt;

  assign lt = sf ^ of;

  always_comb begin
    cnd = 1'b0;
    case (ifun)
      C_YES:   cnd = 1'b1;
      C_LE:    cnd = lt | zf;
      C_L:     cnd = lt;
      C_E:     cnd = zf;
      C_NE:    cnd = ~zf;
      C_GE:    cnd = ~lt;
      C_G:     cnd = ~lt & ~zf;
      default: cnd = 1'b0;
    endcase
  end

endmodule

// File: rtl/execute_cc_stage.sv
// Execute-stage back half: condition-code register, branch/cmov condition,
// cmov destination gating, and the E->M pipeline register with stall/bubble.
module execute_cc_stage
  import y86_pkg::*;
#(
  parameter int unsigned W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   E_stat,
  input  logic [3:0]   E_icode,
  input  logic [3:0]   E_ifun,
  input  logic [W-1:0] E_valA,
  input  logic [3:0]   E_dstE,
  input  logic [3:0]   E_dstM,
  input  logic [W-1:0] e_ans,
  input  logic         e_ovf,
  input  logic         set_cc,
  input  logic         cc_suppress,
  input  logic         M_stall,
  input  logic         M_bubble,
  output logic         zf,
  output logic         sf,
  output logic         of,
  output logic         e_cnd,
  output logic [3:0]   e_dstE,
  output logic [1:0]   M_stat,
  output logic [3:0]   M_icode,
  output logic         M_cnd,
  output logic [W-1:0] M_valE,
  output logic [W-1:0] M_valA,
  output logic [3:0]   M_dstE,
  output logic [3:0]   M_dstM
);

  cc_t  cc_q;
  cc_t  cc_new;
  logic cc_load;

  assign cc_new.zf = (e_ans == '0);
  assign cc_new.sf = e_ans[W-1];
  assign cc_new.of = e_ovf;
  assign cc_load   = set_cc & ~cc_suppress;

  // CC gating is independent of M_stall: a stalled M stage does not freeze E.
  always_ff @(posedge clk) begin
    if (rst) begin
      cc_q <= CC_RESET;
    end else if (cc_load) begin
      cc_q <= cc_new;
    end
  end

  assign zf = cc_q.zf;
  assign sf = cc_q.sf;
  assign of = cc_q.of;

  cond_eval u_cond_eval (
    .ifun (E_ifun),
    .zf   (cc_q.zf),
    .sf   (cc_q.sf),
    .of   (cc_q.of),
    .cnd  (e_cnd)
  );

  assign e_dstE = ((E_icode == I_CMOVXX) && !e_cnd) ? RNONE : E_dstE;

  // Local copy of the pipeline register so the datapath width follows W.
  logic [1:0]   m_stat_q;
  logic [3:0]   m_icode_q;
  logic         m_cnd_q;
  logic [W-1:0] m_val_e_q;
  logic [W-1:0] m_val_a_q;
  logic [3:0]   m_dst_e_q;
  logic [3:0]   m_dst_m_q;

  always_ff @(posedge clk) begin
    if (rst || (!M_stall && M_bubble)) begin
      m_stat_q  <= STAT_AOK;
      m_icode_q <= I_NOP;
      m_cnd_q   <= 1'b0;
      m_val_e_q <= '0;
      m_val_a_q <= '0;
      m_dst_e_q <= RNONE;
      m_dst_m_q <= RNONE;
    end else if (!M_stall) begin
      m_stat_q  <= E_stat;
      m_icode_q <= E_icode;
      m_cnd_q   <= e_cnd;
      m_val_e_q <= e_ans;
      m_val_a_q <= E_valA;
      m_dst_e_q <= e_dstE;
      m_dst_m_q <= E_dstM;
    end
  end

  assign M_stat  = m_stat_q;
  assign M_icode = m_icode_q;
  assign M_cnd   = m_cnd_q;
  assign M_valE  = m_val_e_q;
  assign M_valA  = m_val_a_q;
  assign M_dstE  = m_dst_e_q;
  assign M_dstM  = m_dst_m_q;

endmodule

// File: tb/tb_execute_cc_stage.sv
// Directed bench for execute_cc_stage: flag capture, condition evaluation,
// cmov gating, suppression, stall/bubble priority and mid-run reset.
module tb_execute_cc_stage;

  localparam int W = 64;

  logic         clk;
  logic         rst;
  logic [1:0]   E_stat;
  logic [3:0]   E_icode;
  logic [3:0]   E_ifun;
  logic [W-1:0] E_valA;
  logic [3:0]   E_dstE;
  logic [3:0]   E_dstM;
  logic [W-1:0] e_ans;
  logic         e_ovf;
  logic         set_cc;
  logic         cc_suppress;
  logic         M_stall;
  logic         M_bubble;
  logic         zf, sf, of;
  logic         e_cnd;
  logic [3:0]   e_dstE;
  logic [1:0]   M_stat;
  logic [3:0]   M_icode;
  logic         M_cnd;
  logic [W-1:0] M_valE;
  logic [W-1:0] M_valA;
  logic [3:0]   M_dstE;
  logic [3:0]   M_dstM;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  execute_cc_stage #(.W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .E_stat      (E_stat),
    .E_icode     (E_icode),
    .E_ifun      (E_ifun),
    .E_valA      (E_valA),
    .E_dstE      (E_dstE),
    .E_dstM      (E_dstM),
    .e_ans       (e_ans),
    .e_ovf       (e_ovf),
    .set_cc      (set_cc),
    .cc_suppress (cc_suppress),
    .M_stall     (M_stall),
    .M_bubble    (M_bubble),
    .zf          (zf),
    .sf          (sf),
    .of          (of),
    .e_cnd       (e_cnd),
    .e_dstE      (e_dstE),
    .M_stat      (M_stat),
    .M_icode     (M_icode),
    .M_cnd       (M_cnd),
    .M_valE      (M_valE),
    .M_valA      (M_valA),
    .M_dstE      (M_dstE),
    .M_dstM      (M_dstM)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_e(input logic [3:0] icode, input logic [3:0] ifun,
                         input logic [W-1:0] ans, input logic ovf,
                         input logic [3:0] dst_e, input logic [W-1:0] val_a);
    E_stat  = 2'd1;
    E_icode = icode;
    E_ifun  = ifun;
    e_ans   = ans;
    e_ovf   = ovf;
    E_dstE  = dst_e;
    E_valA  = val_a;
    E_dstM  = 4'hF;
  endtask

  task automatic check_bubble(input string tag);
    check({tag, "_stat"},  M_stat,  2'd1);
    check({tag, "_icode"}, M_icode, 4'h1);
    check({tag, "_cnd"},   M_cnd,   1'b0);
    check({tag, "_valE"},  M_valE,  '0);
    check({tag, "_valA"},  M_valA,  '0);
    check({tag, "_dstE"},  M_dstE,  4'hF);
    check({tag, "_dstM"},  M_dstM,  4'hF);
  endtask

  task automatic check_cc(input string tag, input logic z, input logic s, input logic o);
    check({tag, "_zf"}, zf, z);
    check({tag, "_sf"}, sf, s);
    check({tag, "_of"}, of, o);
  endtask

  initial begin
    rst = 1'b1;
    set_cc = 1'b0;
    cc_suppress = 1'b0;
    M_stall = 1'b0;
    M_bubble = 1'b0;
    drive_e(4'h6, 4'h0, 64'h99, 1'b0, 4'h2, 64'h3);
    step();
    step();
    rst = 1'b0;

    // Reset state
    check_cc("rst", 1'b1, 1'b0, 1'b0);
    check_bubble("rst_m");
    E_ifun = 4'h3;
    #1 check("rst_cnd_e", e_cnd, 1'b1);

    // Flag capture: negative result with overflow; le sees old ZF=1 on this edge
    drive_e(4'h6, 4'h1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 4'h3, 64'h7);
    set_cc = 1'b1;
    #1 check("cap_cnd_before", e_cnd, 1'b1);
    step();
    set_cc = 1'b0;
    check_cc("cap", 1'b0, 1'b1, 1'b1);
    check("cap_M_valE", M_valE, 64'hFFFF_FFFF_FFFF_FFFE);
    check("cap_M_icode", M_icode, 4'h6);
    check("cap_M_cnd", M_cnd, 1'b1);
    check("cap_M_valA", M_valA, 64'h7);
    check("cap_M_dstE", M_dstE, 4'h3);

    // Conditions with Z=0 S=1 O=1
    E_ifun = 4'h2; #1 check("cnd_l", e_cnd, 1'b0);
    E_ifun = 4'h1; #1 check("cnd_le", e_cnd, 1'b0);
    E_ifun = 4'h5; #1 check("cnd_ge", e_cnd, 1'b1);
    E_ifun = 4'h4; #1 check("cnd_ne", e_cnd, 1'b1);
    E_ifun = 4'h6; #1 check("cnd_g", e_cnd, 1'b1);
    E_ifun = 4'h3; #1 check("cnd_e", e_cnd, 1'b0);
    E_ifun = 4'h9; #1 check("cnd_undef", e_cnd, 1'b0);

    // Suppression: CC holds, M still loads
    drive_e(4'h6, 4'h0, 64'h0, 1'b0, 4'h4, 64'h0);
    set_cc = 1'b1;
    cc_suppress = 1'b1;
    step();
    set_cc = 1'b0;
    cc_suppress = 1'b0;
    check_cc("supp", 1'b0, 1'b1, 1'b1);
    check("supp_M_valE", M_valE, 64'h0);
    check("supp_M_dstE", M_dstE, 4'h4);

    // Cmov gating with ZF=0 and cmove
    drive_e(4'h2, 4'h3, 64'h55, 1'b0, 4'h3, 64'h55);
    #1 check("cmov_e_dstE", e_dstE, 4'hF);
    step();
    check("cmov_M_cnd", M_cnd, 1'b0);
    check("cmov_M_dstE", M_dstE, 4'hF);
    check("cmov_M_icode", M_icode, 4'h2);
    E_icode = 4'h6;
    #1 check("opq_e_dstE", e_dstE, 4'h3);

    // 0x8000..0 + 0x8000..0: ans=0, ZF=1, OF=1
    drive_e(4'h6, 4'h0, 64'h0, 1'b1, 4'h1, 64'h0);
    set_cc = 1'b1;
    step();
    set_cc = 1'b0;
    check_cc("ovf", 1'b1, 1'b0, 1'b1);
    E_ifun = 4'h1; #1 check("ovf_le", e_cnd, 1'b1);
    E_ifun = 4'h2; #1 check("ovf_l", e_cnd, 1'b1);
    E_ifun = 4'h6; #1 check("ovf_g", e_cnd, 1'b0);

    // Stall: M_valE stays at 0x1234 while E keeps changing
    drive_e(4'h6, 4'h0, 64'h1234, 1'b0, 4'h5, 64'h0);
    step();
    check("load_M_valE", M_valE, 64'h1234);
    M_stall = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      drive_e(4'h7, 4'h0, 64'h1111 * i, 1'b0, 4'h6, 64'h9);
      // CC keeps updating under stall on the final stalled edge
      if (i == 3) begin
        e_ans = 64'h8000_0000_0000_0000;
        set_cc = 1'b1;
      end
      exp_q.push_back(64'h1234);
      step();
      check("stall_M_valE", M_valE, exp_q.pop_front());
      check("stall_M_icode", M_icode, 4'h6);
    end
    set_cc = 1'b0;
    check_cc("stall_cc", 1'b0, 1'b1, 1'b0);

    // Bubble
    M_stall = 1'b0;
    M_bubble = 1'b1;
    step();
    check_bubble("bub");

    // Stall + bubble together: hold
    M_bubble = 1'b0;
    drive_e(4'h6, 4'h0, 64'hABCD, 1'b0, 4'h7, 64'h1);
    E_dstM = 4'h5;
    step();
    check("pre_sb_M_valE", M_valE, 64'hABCD);
    check("pre_sb_M_dstM", M_dstM, 4'h5);
    M_stall = 1'b1;
    M_bubble = 1'b1;
    drive_e(4'h3, 4'h0, 64'h7777, 1'b0, 4'h8, 64'h2);
    step();
    check("sb_M_valE", M_valE, 64'hABCD);
    check("sb_M_icode", M_icode, 4'h6);
    check("sb_M_dstM", M_dstM, 4'h5);

    // Mid-run reset beats stall, bubble and set_cc
    e_ans = 64'h5;
    e_ovf = 1'b1;
    set_cc = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_cc = 1'b0;
    M_stall = 1'b0;
    M_bubble = 1'b0;
    check_cc("mrst", 1'b1, 1'b0, 1'b0);
    check_bubble("mrst_m");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/execute_cc_stage.md
# execute_cc_stage

Execute-stage back half of the Y86-64 pipeline, directly downstream of the 64-bit ALU. It captures the ALU result into the condition-code register (ZF/SF/OF) and evaluates the branch/cmov condition `e_cnd` against the current flags. It gates `dstE` for conditional moves and holds the E→M pipeline register, with stall and bubble control, that feeds the memory stage.

## Interface
Parameters:
- `W`, 64, datapath width (ALU result, valE, valA)

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `E_stat`  in  2  status of instruction in E
- `E_icode`  in  4  instruction code in E
- `E_ifun`  in  4  function code in E (condition selector for jXX/cmovXX)
- `E_valA`  in  W  operand A forwarded to M
- `E_dstE`  in  4  requested E destination register
- `E_dstM`  in  4  memory destination register
- `e_ans`  in  W  ALU result (signed)
- `e_ovf`  in  1  ALU signed-overflow flag
- `set_cc`  in  1  instruction in E is OPq and may update CC
- `cc_suppress`  in  1  exception in M or W; blocks CC update
- `M_stall`  in  1  hold the E→M register
- `M_bubble`  in  1  load a NOP bubble into the E→M register
- `zf`, `sf`, `of`  out  1 each  current CC register
- `e_cnd`  out  1  condition result, combinational from the current CC and `E_ifun`
- `e_dstE`  out  4  `E_dstE`, or `RNONE` (4'hF) when `E_icode`=CMOVXX and `e_cnd`=0
- `M_stat`  out  2  registered
- `M_icode`  out  4  registered
- `M_cnd`  out  1  registered
- `M_valE`  out  W  registered ALU result
- `M_valA`  out  W  registered
- `M_dstE`  out  4  registered
- `M_dstM`  out  4  registered

## Operation
- Flags computed from the ALU output: ZF = (`e_ans`==0); SF = `e_ans[W-1]`; OF = `e_ovf`. ALU ifun encodings: 0 add, 1 sub, 2 and, 3 xor. The ALU clears OF for and/xor.
- The CC register loads {ZF,SF,OF} when `set_cc` & ~`cc_suppress`. Otherwise it holds.
- `e_cnd` is derived from `E_ifun` and the flags currently held in the CC register, before any update on this edge:
  - 0 always → 1
  - 1 le → (SF^OF)|ZF
  - 2 l → SF^OF
  - 3 e → ZF
  - 4 ne → ~ZF
  - 5 ge → ~(SF^OF)
  - 6 g → ~(SF^OF)&~ZF
  - 7–15 → 0
- `e_dstE` is gated only for `E_icode`=CMOVXX (4'h2). For all other icodes it passes `E_dstE` through.
- E→M register behaviour, in priority order:
  - `rst` loads bubble.
  - Else `M_stall` holds all M_* outputs.
  - Else `M_bubble` loads bubble.
  - Else it loads {`E_stat`, `E_icode`, `e_cnd`, `e_ans`, `E_valA`, `e_dstE`, `E_dstM`}.
- Bubble value: `M_stat`=AOK (2'd1), `M_icode`=NOP (4'h1), `M_cnd`=0, `M_valE`=0, `M_valA`=0, `M_dstE`=`M_dstM`=RNONE.
- `M_stall` does not block the CC update. CC gating depends only on `set_cc`/`cc_suppress`.

## Timing
- Reset values: `zf`=1, `sf`=0, `of`=0. All M_* outputs take the bubble value. `e_cnd`/`e_dstE` follow from these combinationally.
- Flag latency: an OPq in E at edge n updates CC at edge n. A jXX/cmovXX in E during cycle n+1 sees the new flags.
- M_* latency is 1 cycle from the E inputs.
- `e_cnd` has zero latency from CC and `E_ifun`.
- `rst` asserted mid-stream wins over stall, bubble and `set_cc` on the same edge.
- `M_stall` and `M_bubble` asserted together: stall wins and the register holds.
- `set_cc` with `cc_suppress` = 1: CC holds, while M_* still loads normally.
- Overflow edge cases: 0x7FFF…F + 0x7FFF…F gives ans=0xFFFF…FE and OF=1. 0x8000…0 + 0x8000…0 gives ans=0, ZF=1, OF=1.

## Structure
- Shared package `y86_pkg` holds:
  - icode constants (NOP, CMOVXX, OPQ, JXX, …)
  - stat codes (AOK/HLT/ADR/INS)
  - condition ifun codes (C_YES…C_G)
  - ALU ifun codes
  - `RNONE`
- One sub-module, `cond_eval`: purely combinational, {ifun, zf, sf, of} → cnd. The same module is reused in fetch-side branch logic.
- The CC register and E→M register are flops in the top module.

## Test plan
- Reset: hold `rst` 2 cycles → `zf`=1, `sf`=0, `of`=0; `M_icode`=4'h1, `M_stat`=1, `M_dstE`=4'hF.
- Flag capture:
  - `e_ans`=0xFFFF_FFFF_FFFF_FFFE, `e_ovf`=1, `set_cc`=1 → next cycle `zf`=0, `sf`=1, `of`=1.
  - Then `E_ifun`=2 (l) → `e_cnd`=0.
  - Then `E_ifun`=1 (le) → `e_cnd`=0.
- Suppression: `set_cc`=1, `cc_suppress`=1, `e_ans`=0 → CC unchanged. `M_valE`=0 is still loaded.
- Cmov gating:
  - `zf`=0, `E_icode`=2, `E_ifun`=3, `E_dstE`=4'h3 → `e_dstE`=4'hF, `M_cnd`=0 next edge.
  - Same with `E_icode`=6 → `e_dstE`=4'h3.
- Stall/bubble:
  - Load `M_valE`=0x1234, then `M_stall`=1 with new inputs for 3 cycles → `M_valE` stays 0x1234.
  - Then `M_bubble`=1 → `M_icode`=1, `M_valE`=0.
  - Stall+bubble together → hold.
- Mid-run reset: assert `rst` on the same edge as `set_cc` with `e_ans`=5 → CC returns to Z=1,S=0,O=0 and M_* take the bubble value.
